// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between the icache and the dcache.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ic_*                     icache requester: line read request, ready pulse, read beats
//   dc_*                     dcache requester: line read or write burst, ready, read beats
//   mem_*                    memory port: request/write beat out, ready and read beats in
//   stray_beat               sticky: a read beat arrived that matched no outstanding read
//
// One owner holds the port for a full line transaction (request + BURST_LEN read beats, or
// BURST_LEN write beats). Ties in IDLE go to the requester that was not granted last.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_read,
  output logic                  ic_ready,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic [ADDR_WIDTH-1:0] ic_raddr,
  output logic                  ic_rvalid,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_ready,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic [ADDR_WIDTH-1:0] dc_raddr,
  output logic                  dc_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  output logic                  stray_beat
);

  localparam int unsigned CntW = $clog2(BURST_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
  localparam logic OwnIc = 1'b0;
  localparam logic OwnDc = 1'b1;

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrBurst} state_e;

  state_e                r_state, w_state_next;
  logic                  r_owner, w_owner_next;
  logic                  r_rr_last, w_rr_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic                  r_stray, w_stray_set;
  logic                  w_ic_req, w_dc_req, w_beat_ok;

  assign w_ic_req   = ic_read;
  assign w_dc_req   = dc_read | dc_write;
  assign w_beat_ok  = (r_state == StRdWait) && mem_rvalid && (mem_raddr == r_addr);
  assign stray_beat = r_stray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_owner   <= OwnIc;
      r_rr_last <= OwnIc;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_stray   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_rr_last <= w_rr_next;
      r_cnt     <= w_cnt_next;
      r_addr    <= w_addr_next;
      r_stray   <= r_stray | w_stray_set;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr_last;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_stray_set  = mem_rvalid & ~w_beat_ok;
    ic_ready     = 1'b0;
    ic_rdata     = '0;
    ic_raddr     = '0;
    ic_rvalid    = 1'b0;
    dc_ready     = 1'b0;
    dc_rdata     = '0;
    dc_raddr     = '0;
    dc_rvalid    = 1'b0;
    mem_addr     = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;

    case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_dc_req && (!w_ic_req || r_rr_last == OwnIc)) begin
          w_owner_next = OwnDc;
          w_rr_next    = OwnDc;
          w_addr_next  = dc_addr;
          // A dirty writeback must leave before the refill read of the same set.
          w_state_next = dc_write ? StWrBurst : StRdReq;
        end else if (w_ic_req) begin
          w_owner_next = OwnIc;
          w_rr_next    = OwnIc;
          w_addr_next  = ic_addr;
          w_state_next = StRdReq;
        end
      end

      StRdReq: begin
        mem_read = 1'b1;
        mem_addr = r_addr;
        if (mem_ready) begin
          ic_ready     = (r_owner == OwnIc);
          dc_ready     = (r_owner == OwnDc);
          w_cnt_next   = '0;
          w_state_next = StRdWait;
        end
      end

      StRdWait: begin
        if (w_beat_ok) begin
          if (r_owner == OwnIc) begin
            ic_rvalid = 1'b1;
            ic_rdata  = mem_rdata;
            ic_raddr  = mem_raddr;
          end else begin
            dc_rvalid = 1'b1;
            dc_rdata  = mem_rdata;
            dc_raddr  = mem_raddr;
          end
          w_cnt_next = r_cnt + CntW'(1);
          if (r_cnt == LastBeat) w_state_next = StIdle;
        end
      end

      StWrBurst: begin
        mem_write = dc_write;
        mem_wdata = dc_wdata;
        mem_addr  = r_addr;
        dc_ready  = mem_ready;
        // A gap in dc_write only stalls; the burst always completes BURST_LEN beats.
        if (mem_ready && dc_write) begin
          w_cnt_next = r_cnt + CntW'(1);
          if (r_cnt == LastBeat) w_state_next = StIdle;
        end
      end

      default: w_state_next = StIdle;
    endcase
  end

endmodule
